// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage with integrated MEM/WB result register and Done handshake.
// Optional watchdog on the memory wait is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic              mem_to_reg,
  input  logic              reg_write_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  input  logic              m_err,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              reg_write_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              err
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic               cap_m2r;
  logic               cap_rw;
  logic [REG_W-1:0]   cap_wreg;
  logic [ADDR_W-1:0]  cap_addr;
  logic               accept;
  logic               tmo;

  assign accept = (state == IDLE) && in_valid && mem_en && !addr[0];

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wdog;

  // Fires in the last waiting cycle so the stage is back in IDLE exactly TIMEOUT cycles later.
  assign tmo = (state == BUSY) && !m_done && (wdog == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || accept) wdog <= '0;
    else if (state == BUSY && !m_done) wdog <= wdog + 16'd1;
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = (TIMEOUT > 1);
`endif

  // Strobes and stall are gated by reset so nothing leaks out while the stage is held.
  assign m_rd    = rst && accept && !mem_wr;
  assign m_wr    = rst && accept && mem_wr;
  assign m_addr  = addr;
  assign m_wdata = wdata;
  assign stall   = rst && (accept || ((state == BUSY) && !m_done && !tmo));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      wb_data       <= '0;
      reg_write_out <= 1'b0;
      write_reg_out <= '0;
      err           <= 1'b0;
      cap_m2r       <= 1'b0;
      cap_rw        <= 1'b0;
      cap_wreg      <= '0;
      cap_addr      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_en) begin
              wb_data       <= DATA_W'(addr);
              reg_write_out <= reg_write_in;
              write_reg_out <= write_reg_in;
              err           <= 1'b0;
              out_valid     <= 1'b1;
            end else if (addr[0]) begin
              wb_data       <= '0;
              reg_write_out <= 1'b0;
              write_reg_out <= write_reg_in;
              err           <= 1'b1;
              out_valid     <= 1'b1;
            end else begin
              cap_m2r  <= mem_to_reg;
              cap_rw   <= reg_write_in;
              cap_wreg <= write_reg_in;
              cap_addr <= addr;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (m_done) begin
            wb_data       <= cap_m2r ? m_rdata : DATA_W'(cap_addr);
            err           <= m_err;
            reg_write_out <= cap_rw && !m_err;
            write_reg_out <= cap_wreg;
            out_valid     <= 1'b1;
            state         <= IDLE;
          end else if (tmo) begin
            wb_data       <= '0;
            err           <= 1'b1;
            reg_write_out <= 1'b0;
            write_reg_out <= cap_wreg;
            out_valid     <= 1'b1;
            state         <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Parametrised memory-access pipeline stage with an integrated MEM/WB output register, succeeding the fixed 16-bit memory stage. Accepts one instruction per cycle from the execute stage and issues a single-cycle read or write request to a multi-cycle memory system with a Done handshake. Stalls upstream until the access completes, then selects load data or ALU result for writeback. Detects misaligned accesses and memory errors; an optional watchdog bounds the wait.

## Interface
- DATA_W, 16, data and ALU-result width
- ADDR_W, 16, address width
- REG_W, 3, destination register index width
- TIMEOUT, 64, watchdog limit in cycles; legal 2..65535; used only with MEM_TIMEOUT_EN

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  instruction present from execute
- mem_en  in  1  instruction accesses memory
- mem_wr  in  1  access is a store; a load when 0
- mem_to_reg  in  1  writeback selects load data; ALU result when 0
- reg_write_in  in  1  instruction writes a register
- write_reg_in  in  REG_W  destination register
- addr  in  ADDR_W  ALU result / memory address
- wdata  in  DATA_W  store data
- m_rd, m_wr  out  1  one-cycle request strobes to memory
- m_addr  out  ADDR_W  request address, valid with strobe
- m_wdata  out  DATA_W  store data, valid with m_wr
- m_rdata  in  DATA_W  load data, valid when m_done
- m_done  in  1  access complete, single-cycle pulse
- m_err  in  1  memory error, sampled with m_done
- stall  out  1  upstream must hold its inputs this cycle
- out_valid  out  1  registered result valid for writeback
- wb_data  out  DATA_W  registered writeback value
- reg_write_out  out  1  registered reg_write_in, qualified by out_valid
- write_reg_out  out  REG_W  registered destination
- err  out  1  registered error, qualified by out_valid

## Operation
- States: IDLE, BUSY.
- IDLE, in_valid=0: out_valid<=0.
- IDLE, in_valid=1, mem_en=0: result register loads addr, out_valid<=1, err<=0; stay IDLE.
- IDLE, in_valid=1, mem_en=1, addr[0]=1 (misaligned): no strobe; out_valid<=1, err<=1, wb_data<=0, reg_write_out<=0.
- IDLE, in_valid=1, mem_en=1, aligned: m_rd=~mem_wr or m_wr=mem_wr asserted combinationally that cycle; mem_to_reg, reg_write_in, write_reg_in, addr captured; go BUSY; out_valid<=0.
- BUSY, m_done=0: stall=1, no strobes, out_valid<=0.
- BUSY, m_done=1: wb_data<=mem_to_reg ? m_rdata : captured addr; err<=m_err; reg_write_out<=captured reg_write & ~m_err; out_valid<=1; go IDLE.
- stall = (IDLE & in_valid & mem_en & ~addr[0]) | (BUSY & ~m_done).
- m_done in IDLE ignored. m_err outside m_done ignored.
- Outputs other than out_valid hold their last value when out_valid=0.

## Timing
- Reset (rst=0 at edge): state IDLE, out_valid=0, wb_data=0, reg_write_out=0, write_reg_out=0, err=0, watchdog=0. m_rd, m_wr, stall are 0 while rst=0.
- Reset in BUSY aborts the access; m_done arriving after reset is ignored.
- Non-memory and misaligned: out_valid 1 cycle after acceptance; back-to-back each cycle.
- Memory op: strobe at cycle 0; m_done at cycle N (N≥1); out_valid at N+1. A new instruction can be accepted in cycle N+1.
- m_done in the strobe cycle is impossible by contract; ignore it.

## Configuration
- MEM_TIMEOUT_EN defined: counter clears on entry to BUSY and increments each BUSY cycle without m_done; when it reaches TIMEOUT, go IDLE, out_valid<=1, err<=1, wb_data<=0, reg_write_out<=0, stall drops the same cycle. A later m_done is ignored.
- Not defined: no counter; BUSY waits indefinitely.

## Test plan
- ALU pass-through: three back-to-back non-memory ops addr=0x0011,0x0022,0x0033 -> out_valid on three consecutive cycles, wb_data in order, stall=0 throughout.
- Load: addr=0x0040, mem_to_reg=1, m_done after 4 cycles with m_rdata=0xBEEF -> m_rd single pulse, stall high 4 cycles, wb_data=0xBEEF, err=0 one cycle later.
- Store then misaligned load: store to 0x0010 completes; then load addr=0x0013 -> no strobe, out_valid with err=1, reg_write_out=0.
- Memory error: load with m_err=1 at m_done -> err=1, reg_write_out=0.
- Reset mid-access: rst=0 during BUSY, then m_done pulse -> outputs all 0, state IDLE, out_valid stays 0.
- MEM_TIMEOUT_EN, TIMEOUT=8, m_done never asserted -> err=1 with out_valid exactly 9 cycles after the strobe, stall low afterwards.
